vga_timing_out: RTL and testbench

Display timing generator and registered pixel output stage for the VGA path. It divides the system clock down to the pixel rate and produces the `h_counter`/`v_counter` scan position that every glyph/drawing block consumes. It registers the drawing layer's combinational `R`/`G`/`B` into the DAC outputs with blanking and sync aligned to the same pixel. Default timing is 640x480@60 Hz from a 50 MHz clock.

---
 rtl/vga_timing_out.sv | 124 ++++++++++++
 tb/tb_vga_timing_out.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_out.sv
// rtl/vga_timing_out.sv - VGA scan timing generator with registered colour/blank/sync output stage
module vga_timing_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h_counter,
    output logic [9:0] v_counter,
    output logic       pix_en,
    output logic       frame_start,
    input  logic [7:0] R_in,
    input  logic [7:0] G_in,
    input  logic [7:0] B_in,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q, pix_en_d;
    logic             vga_clk_q, vga_clk_d;
    logic             frame_start_q, frame_start_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic             blank_n_q, blank_n_d, hs_q, hs_d, vs_q, vs_d;
    logic             h_last, v_last, active, hsync_on, vsync_on;

    always_comb begin
        h_last   = (h_q == 10'(H_TOTAL - 1));
        v_last   = (v_q == 10'(V_TOTAL - 1));
        active   = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
        hsync_on = (h_q >= 10'(H_ACTIVE + H_FRONT)) && (h_q < 10'(H_ACTIVE + H_FRONT + H_SYNC));
        vsync_on = (v_q >= 10'(V_ACTIVE + V_FRONT)) && (v_q < 10'(V_ACTIVE + V_FRONT + V_SYNC));
    end

    // Strobes are decoded from the next divider value so they line up with div itself.
    always_comb begin
        div_d         = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
        pix_en_d      = (div_d == DIV_W'(CLK_DIV - 1));
        vga_clk_d     = (div_d >= DIV_W'(CLK_DIV / 2));
        frame_start_d = pix_en_q && h_last && v_last;
        h_d           = h_q;
        v_d           = v_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        blank_n_d     = blank_n_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        if (pix_en_q) begin
            h_d = h_last ? 10'd0 : h_q + 10'd1;
            if (h_last) begin
                v_d = v_last ? 10'd0 : v_q + 10'd1;
            end
            r_d       = active ? R_in : 8'd0;
            g_d       = active ? G_in : 8'd0;
            b_d       = active ? B_in : 8'd0;
            blank_n_d = active;
            hs_d      = ~hsync_on;
            vs_d      = ~vsync_on;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            vga_clk_q     <= 1'b0;
            frame_start_q <= 1'b0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            r_q           <= 8'd0;
            g_q           <= 8'd0;
            b_q           <= 8'd0;
            blank_n_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= pix_en_d;
            vga_clk_q     <= vga_clk_d;
            frame_start_q <= frame_start_d;
            h_q           <= h_d;
            v_q           <= v_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            blank_n_q     <= blank_n_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign h_counter   = h_q;
    assign v_counter   = v_q;
    assign pix_en      = pix_en_q;
    assign frame_start = frame_start_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vga_clk_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// tb/tb_vga_timing_out.sv - directed bench for vga_timing_out on a reduced raster
module tb_vga_timing_out;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int CD = 4;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME_PIX = HT * VT;
    localparam int FRAME_CLK = FRAME_PIX * CD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] h_counter, v_counter;
    logic       pix_en, frame_start;
    logic [7:0] R_in, G_in, B_in;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
    int         color_mode = 0;
    int         vectors = 0;
    int         miscompares = 0;

    vga_timing_out #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(CD)
    ) dut (
        .clk(clk), .reset(reset),
        .h_counter(h_counter), .v_counter(v_counter),
        .pix_en(pix_en), .frame_start(frame_start),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
    );

    always #5 clk = ~clk;

    // Drawing layer: position pattern, garbage when pix_en is low, or flat white.
    always_comb begin
        if (color_mode == 1) begin
            R_in = 8'hFF;
            G_in = 8'hFF;
            B_in = 8'hFF;
        end else if (pix_en) begin
            R_in = {h_counter[3:0], v_counter[3:0]};
            G_in = ~{h_counter[3:0], v_counter[3:0]};
            B_in = h_counter[7:0] ^ 8'h3C;
        end else begin
            R_in = 8'h55;
            G_in = 8'h55;
            B_in = 8'h55;
        end
    end

    task automatic check_reset_values(input string tag);
        vectors++;
        if ({h_counter, v_counter, pix_en, frame_start, VGA_CLK, VGA_R, VGA_G, VGA_B,
             VGA_BLANK_N, VGA_HS, VGA_VS, VGA_SYNC_N} !== {20'd0, 3'b000, 24'd0, 4'b0110}) begin
            miscompares++;
            $display("FAIL %s: h=%0d v=%0d pe=%b fs=%b vclk=%b rgb=%h%h%h bn=%b hs=%b vs=%b sn=%b, required all zero with hs=vs=1",
                     tag, h_counter, v_counter, pix_en, frame_start, VGA_CLK, VGA_R, VGA_G, VGA_B,
                     VGA_BLANK_N, VGA_HS, VGA_VS, VGA_SYNC_N);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset_state");
    endtask

    // Releases reset at a negedge and checks every sample against a model indexed by edge count.
    task automatic test_scan(input int n_edges, input int mode, input string tag);
        int div_e, p, pf, pp;
        logic [9:0] eh, ev, ph, pv;
        logic e_pe, e_vclk, e_fs, act, hs_on, vs_on;
        logic [7:0] er, eg, eb;
        color_mode = mode;
        reset = 1'b1;
        for (int k = 0; k < n_edges; k++) begin
            @(posedge clk);
            @(negedge clk);
            div_e  = (k + 1) % CD;
            p      = (k + 1) / CD;
            pf     = p % FRAME_PIX;
            eh     = 10'(pf % HT);
            ev     = 10'(pf / HT);
            e_pe   = (div_e == CD - 1);
            e_vclk = (div_e >= CD / 2);
            e_fs   = (div_e == 0) && (p > 0) && (pf == 0);
            er = 8'd0; eg = 8'd0; eb = 8'd0;
            act = 1'b0; hs_on = 1'b0; vs_on = 1'b0;
            if (p > 0) begin
                pp    = (p - 1) % FRAME_PIX;
                ph    = 10'(pp % HT);
                pv    = 10'(pp / HT);
                act   = (ph < HA) && (pv < VA);
                hs_on = (ph >= HA + HF) && (ph < HA + HF + HSW);
                vs_on = (pv >= VA + VF) && (pv < VA + VF + VSW);
                if (act) begin
                    if (mode == 1) begin
                        er = 8'hFF; eg = 8'hFF; eb = 8'hFF;
                    end else begin
                        er = {ph[3:0], pv[3:0]};
                        eg = ~{ph[3:0], pv[3:0]};
                        eb = ph[7:0] ^ 8'h3C;
                    end
                end
            end
            vectors++;
            if ({h_counter, v_counter} !== {eh, ev}) begin
                miscompares++;
                $display("FAIL %s_pos k=%0d: h=%0d v=%0d, required h=%0d v=%0d", tag, k, h_counter, v_counter, eh, ev);
            end
            vectors++;
            if ({pix_en, frame_start, VGA_CLK} !== {e_pe, e_fs, e_vclk}) begin
                miscompares++;
                $display("FAIL %s_strobes k=%0d: pe/fs/vclk=%b%b%b, required %b%b%b", tag, k,
                         pix_en, frame_start, VGA_CLK, e_pe, e_fs, e_vclk);
            end
            vectors++;
            if ({VGA_R, VGA_G, VGA_B} !== {er, eg, eb}) begin
                miscompares++;
                $display("FAIL %s_rgb k=%0d: rgb=%h_%h_%h, required %h_%h_%h", tag, k, VGA_R, VGA_G, VGA_B, er, eg, eb);
            end
            vectors++;
            if ({VGA_BLANK_N, VGA_HS, VGA_VS, VGA_SYNC_N} !== {act, ~hs_on, ~vs_on, 1'b0}) begin
                miscompares++;
                $display("FAIL %s_ctl k=%0d: bn/hs/vs/sn=%b%b%b%b, required %b%b%b0", tag, k,
                         VGA_BLANK_N, VGA_HS, VGA_VS, VGA_SYNC_N, act, ~hs_on, ~vs_on);
            end
        end
    endtask

    task automatic test_midframe_reset();
        int i;
        for (i = 0; i < 2 * FRAME_CLK && !(h_counter == 10'd7 && v_counter == 10'd2); i++) @(negedge clk);
        vectors++;
        if (!(h_counter == 10'd7 && v_counter == 10'd2)) begin
            miscompares++;
            $display("FAIL midframe_reach: h=%0d v=%0d, required h=7 v=2 within budget", h_counter, v_counter);
        end
        #2 reset = 1'b0;
        #1 check_reset_values("midframe_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("midframe_held");
    endtask

    task automatic test_frame_period();
        int i, n;
        for (i = 0; i < 2 * FRAME_CLK && !frame_start; i++) @(negedge clk);
        @(negedge clk);
        vectors++;
        if (frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_start_width: frame_start=%b one clk later, required 0", frame_start);
        end
        n = 1;
        for (i = 0; i < 2 * FRAME_CLK && !frame_start; i++) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== FRAME_CLK) begin
            miscompares++;
            $display("FAIL frame_period: %0d clocks, required %0d", n, FRAME_CLK);
        end
    endtask

    task automatic test_sync_widths();
        int i, n;
        for (i = 0; i < 2 * FRAME_CLK && VGA_HS !== 1'b1; i++) @(negedge clk);
        for (i = 0; i < 2 * FRAME_CLK && VGA_HS !== 1'b0; i++) @(negedge clk);
        n = 0;
        for (i = 0; i < 2 * FRAME_CLK && VGA_HS === 1'b0; i++) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== HSW * CD) begin
            miscompares++;
            $display("FAIL hsync_width: %0d clocks low, required %0d", n, HSW * CD);
        end
        for (i = 0; i < 2 * FRAME_CLK && VGA_VS !== 1'b1; i++) @(negedge clk);
        for (i = 0; i < 2 * FRAME_CLK && VGA_VS !== 1'b0; i++) @(negedge clk);
        n = 0;
        for (i = 0; i < 2 * FRAME_CLK && VGA_VS === 1'b0; i++) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== VSW * HT * CD) begin
            miscompares++;
            $display("FAIL vsync_width: %0d clocks low, required %0d", n, VSW * HT * CD);
        end
    endtask

    initial begin
        test_reset();
        test_scan(2 * FRAME_CLK + 20, 0, "scan_pattern");
        test_midframe_reset();
        test_scan(FRAME_CLK + 20, 1, "scan_white");
        test_frame_period();
        test_sync_widths();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
